// File: rtl/mem_ack_unit_pkg.sv
// Shared types and defaults for the memory-side hello/ack handshake slave.
// Default widths track the accumulator CPU's data and address sizes.
package mem_ack_unit_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE = 2'd0,
    MEM_STATE_WAIT = 2'd1,
    MEM_STATE_ACK  = 2'd2
  } mem_state_e;

  // Wait counter width: clog2(wait_cycles+1), never below one bit.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_ack_unit_if.sv
// Request/ack bus between the CPU control unit (master) and memory (slave).
interface mem_ack_unit_if
  import mem_ack_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              hello;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              err;

  modport master (output hello, addr, we, wdata, input ack, rdata, busy, err);
  modport slave  (input hello, addr, we, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/mem_ack_unit_ram_array_sp.sv
// Single-port synchronous RAM: one write port, registered read.
// Accesses to addresses at or beyond DEPTH write nothing and read zero.
module ram_array_sp #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 4,
  parameter int    DEPTH     = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_in_range;

  assign w_in_range = ({1'b0, i_addr} < DEPTH_L);

  // NOTE: the array has no reset so it maps onto block RAM and keeps its
  // contents across rst; only the read register is reset.
  always_ff @(posedge clk) begin
    if (i_we && w_in_range) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= w_in_range ? r_mem[i_addr] : '0;
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_ack_unit.sv
// Memory handshake slave: captures a hello request, waits WAIT_CYCLES, then
// answers with a one-cycle ack carrying read data and an out-of-range flag.
module mem_ack_unit
  import mem_ack_unit_pkg::*;
#(
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    ADDR_W      = ADDR_W_DEF,
  parameter int    DEPTH       = 16,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input logic           clk,
  input logic           rst,
  mem_ack_unit_if.slave bus
);
  localparam int              CNT_W   = cnt_width(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  mem_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_we_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic              r_ack;
  logic              r_busy;
  logic              r_err;

  logic [ADDR_W-1:0] w_port_addr;
  logic              w_in_range;
  logic              w_enter_ack;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_rdata;

  // With zero wait states the read happens on the capture edge itself, so the
  // RAM must see the live address rather than the not-yet-captured copy.
  assign w_port_addr = (r_state == MEM_STATE_IDLE) ? bus.addr : r_addr_q;
  assign w_in_range  = ({1'b0, w_port_addr} < DEPTH_L);
  assign w_enter_ack = ((r_state == MEM_STATE_IDLE) && bus.hello && (WAIT_CYCLES == 0)) ||
                       ((r_state == MEM_STATE_WAIT) && bus.hello && (r_cnt == CNT_W'(1)));
  assign w_ram_we    = (r_state == MEM_STATE_ACK) && r_we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= MEM_STATE_IDLE;
      r_cnt     <= '0;
      r_addr_q  <= '0;
      r_we_q    <= 1'b0;
      r_wdata_q <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: ack/err default low here so every path yields a single-cycle pulse.
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        MEM_STATE_IDLE: begin
          if (bus.hello) begin
            r_addr_q  <= bus.addr;
            r_we_q    <= bus.we;
            r_wdata_q <= bus.wdata;
            r_cnt     <= CNT_W'(WAIT_CYCLES);
            r_busy    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= MEM_STATE_ACK;
              r_ack   <= 1'b1;
              r_err   <= !w_in_range;
            end else begin
              r_state <= MEM_STATE_WAIT;
            end
          end
        end
        MEM_STATE_WAIT: begin
          if (!bus.hello) begin
            r_state <= MEM_STATE_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= MEM_STATE_ACK;
              r_ack   <= 1'b1;
              r_err   <= !w_in_range;
            end
          end
        end
        MEM_STATE_ACK: begin
          r_state <= MEM_STATE_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= MEM_STATE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ram_array_sp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_ram_we),
    .i_re   (w_enter_ack),
    .i_addr (w_port_addr),
    .i_wdata(r_wdata_q),
    .o_rdata(w_rdata)
  );

  assign bus.ack   = r_ack;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;
  assign bus.rdata = w_rdata;
endmodule

// File: tb/tb_mem_ack_unit.sv
// Drives four mem_ack_unit instances (0..3 wait states, one with DEPTH=12) from
// shared stimulus and checks each against a per-request transaction model.
module tb_mem_ack_unit;
  localparam int N = 4;
  localparam int WC_P    [N] = '{0, 1, 2, 3};
  localparam int DEPTH_P [N] = '{16, 16, 16, 12};

  logic       clk = 1'b0;
  logic       rst;
  logic       hello;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;

  logic       ack_o   [N];
  logic       busy_o  [N];
  logic       err_o   [N];
  logic [7:0] rdata_o [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_ack_unit_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    assign bus.hello = hello;
    assign bus.addr  = addr;
    assign bus.we    = we;
    assign bus.wdata = wdata;
    mem_ack_unit #(
      .DATA_W(8), .ADDR_W(4), .DEPTH(DEPTH_P[g]), .WAIT_CYCLES(WC_P[g]), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign ack_o[g]   = bus.ack;
    assign busy_o[g]  = bus.busy;
    assign err_o[g]   = bus.err;
    assign rdata_o[g] = bus.rdata;
  end

  // Transaction model: a request is either pending with some edges left
  // before its ack, or acking; memory is a plain array per instance.
  bit         m_pend   [N];
  int         m_left   [N];
  bit         m_ack    [N];
  bit         m_err    [N];
  logic [7:0] m_rdata  [N];
  bit         m_rknown [N];
  logic [3:0] m_a      [N];
  bit         m_w      [N];
  logic [7:0] m_d      [N];
  logic [7:0] m_mem    [N][16];
  bit         m_known  [N][16];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_left[i] = 0; m_ack[i] = 0; m_err[i] = 0;
      m_rdata[i] = 8'h00; m_rknown[i] = 1;
    end
  endtask

  task automatic complete(input int i);
    m_ack[i] = 1;
    if (int'(m_a[i]) < DEPTH_P[i]) begin
      m_rdata[i] = m_mem[i][m_a[i]]; m_rknown[i] = m_known[i][m_a[i]]; m_err[i] = 0;
    end else begin
      m_rdata[i] = 8'h00; m_rknown[i] = 1; m_err[i] = 1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        m_ack[i] = 0; m_err[i] = 0;
        if (m_w[i] && int'(m_a[i]) < DEPTH_P[i]) begin
          m_mem[i][m_a[i]] = m_d[i]; m_known[i][m_a[i]] = 1;
        end
      end else if (m_pend[i]) begin
        if (!hello) m_pend[i] = 0;
        else begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_pend[i] = 0; complete(i); end
        end
      end else if (hello) begin
        m_a[i] = addr; m_w[i] = we; m_d[i] = wdata;
        if (WC_P[i] == 0) complete(i);
        else begin m_pend[i] = 1; m_left[i] = WC_P[i]; end
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d (wait=%0d depth=%0d) t=%0t: observed %h expected %h",
             tag, i, WC_P[i], DEPTH_P[i], $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("ack",  i, 8'(ack_o[i]),  8'(m_ack[i]));
      chk("busy", i, 8'(busy_o[i]), 8'(m_pend[i] | m_ack[i]));
      chk("err",  i, 8'(err_o[i]),  8'(m_err[i]));
      if (m_rknown[i]) chk("rdata", i, rdata_o[i], m_rdata[i]);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic xfer(input logic [3:0] a, input bit w, input logic [7:0] d, input int hold);
    hello = 1'b1; addr = a; we = w; wdata = d;
    repeat (hold) step();
    hello = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; hello = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'h00;
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 16; a++) m_known[i][a] = 0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step();

    // Fill every word with a known value; word 3 gets A5.
    for (int a = 0; a < 16; a++)
      xfer(4'(a), 1'b1, (a == 3) ? 8'hA5 : 8'($urandom), 5);

    // Read of word 3; write then read of word 5.
    xfer(4'd3, 1'b0, 8'h00, 4);
    xfer(4'd5, 1'b1, 8'h3C, 4);
    xfer(4'd5, 1'b0, 8'h00, 4);

    // hello held 20 cycles: periodic acks every WAIT_CYCLES+2.
    xfer(4'd0, 1'b0, 8'h00, 20);

    // Write to word 7 with hello dropped after two edges, then read it back.
    xfer(4'd7, 1'b1, 8'h99, 2);
    xfer(4'd7, 1'b0, 8'h00, 4);

    // Address 14: out of range on the DEPTH=12 instance.
    xfer(4'd14, 1'b1, 8'h5E, 4);
    xfer(4'd14, 1'b0, 8'h00, 4);

    // Asynchronous reset while a write to word 2 is in flight.
    hello = 1'b1; addr = 4'd2; we = 1'b1; wdata = 8'h77;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3;
    rst = 1'b0; hello = 1'b0; we = 1'b0;
    repeat (2) step();
    xfer(4'd2, 1'b0, 8'h00, 4);

    // Random traffic; addr/we/wdata change freely while requests are in flight.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) hello = ~hello;
      addr  = 4'($urandom_range(0, 15));
      we    = 1'($urandom_range(0, 1));
      wdata = 8'($urandom);
      step();
    end
    hello = 1'b0;
    repeat (3) step();

    // Final read sweep of the whole address space.
    for (int a = 0; a < 16; a++) xfer(4'(a), 1'b0, 8'h00, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
